alu_multicycle: RTL and testbench

- Parametrised, registered successor to the 32-bit combinational ALU. Keeps the existing 4-bit ALUControl encodings.
- Adds shifts, NOR, signed overflow detection and an iterative unsigned multiplier producing a 2*WIDTH product.
- Sits between the ID/EX operand latch and the EX/MEM stage, with valid/ready handshakes on input and output. This lets the pipeline stall on multi-cycle ops.

---
 rtl/alu_multicycle_if.sv | 28 ++
 rtl/alu_multicycle.sv | 134 +++++++++++++
 tb/tb_alu_multicycle.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between the ID/EX latch, the ALU and the EX/MEM stage.
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             InValid;
   logic             InReady;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] ResultHi;
   logic             Zero;
   logic             Overflow;
   logic             Illegal;
   logic             Busy;

   modport master (
      output InValid, ALUControl, A, B, OutReady,
      input  InReady, OutValid, ALUResult, ResultHi, Zero, Overflow, Illegal, Busy
   );

   modport slave (
      input  InValid, ALUControl, A, B, OutReady,
      output InReady, OutValid, ALUResult, ResultHi, Zero, Overflow, Illegal, Busy
   );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle ops return after 1 cycle, MULT iterates one shift-add per cycle.
// Result registers hold while OutValid && !OutReady; no new operation is accepted meanwhile.
module alu_multicycle #(
   parameter int  WIDTH      = 32,
   parameter bit  MUL_ENABLE = 1'b1,
   localparam int SHW        = $clog2(WIDTH)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   alu_multicycle_if.slave   bus
);
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic {IDLE, MUL} state_t;

   state_t               state, state_nxt;
   logic                 out_valid, busy_r, zero_r, ovf_r, ill_r;
   logic [WIDTH-1:0]     res_lo, res_hi, mcand;
   logic [2*WIDTH-1:0]   prod, prod_nxt;
   logic [SHW-1:0]       cnt;
   logic                 in_ready, accept, mul_op, mul_last;
   logic [WIDTH-1:0]     sum, diff, sc_res;
   logic                 sc_ovf, sc_ill;
   logic [WIDTH:0]       step_sum;
   logic [SHW-1:0]       shamt;

   always_comb begin
      state_nxt = state;
      in_ready  = (state == IDLE) && (!out_valid || bus.OutReady);
      accept    = bus.InValid && in_ready;
      mul_op    = MUL_ENABLE && (bus.ALUControl == OP_MUL);
      mul_last  = (state == MUL) && (cnt == SHW'(WIDTH - 1));
      case (state)
         IDLE:    if (accept && mul_op) state_nxt = MUL;
         MUL:     if (mul_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shamt  = bus.B[SHW-1:0];
      sum    = bus.A + bus.B;
      diff   = bus.A - bus.B;
      sc_res = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      case (bus.ALUControl)
         OP_AND: sc_res = bus.A & bus.B;
         OP_OR:  sc_res = bus.A | bus.B;
         OP_NOR: sc_res = ~(bus.A | bus.B);
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_SLL: sc_res = bus.A << shamt;
         OP_SRL: sc_res = bus.A >> shamt;
         OP_SRA: sc_res = $signed(bus.A) >>> shamt;
         default: sc_ill = 1'b1;
      endcase
      // Multiplier bits sit in the low half of prod and are shifted out LSB first.
      step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_nxt = {step_sum, prod[WIDTH-1:1]};
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         out_valid <= 1'b0;
         busy_r    <= 1'b0;
         res_lo    <= '0;
         res_hi    <= '0;
         zero_r    <= 1'b0;
         ovf_r     <= 1'b0;
         ill_r     <= 1'b0;
         cnt       <= '0;
         mcand     <= '0;
         prod      <= '0;
      end else if (accept && !mul_op) begin
         res_lo    <= sc_res;
         res_hi    <= '0;
         zero_r    <= (sc_res == '0);
         ovf_r     <= sc_ovf;
         ill_r     <= sc_ill;
         out_valid <= 1'b1;
      end else if (accept) begin
         mcand     <= bus.A;
         prod      <= {{WIDTH{1'b0}}, bus.B};
         cnt       <= '0;
         busy_r    <= 1'b1;
         out_valid <= 1'b0;
      end else if (state == MUL) begin
         prod <= prod_nxt;
         cnt  <= cnt + 1'b1;
         if (mul_last) begin
            res_lo    <= prod_nxt[WIDTH-1:0];
            res_hi    <= prod_nxt[2*WIDTH-1:WIDTH];
            zero_r    <= (prod_nxt[WIDTH-1:0] == '0);
            ovf_r     <= 1'b0;
            ill_r     <= 1'b0;
            out_valid <= 1'b1;
            busy_r    <= 1'b0;
         end
      end else if (out_valid && bus.OutReady) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.InReady   = in_ready;
   assign bus.OutValid  = out_valid;
   assign bus.ALUResult = res_lo;
   assign bus.ResultHi  = res_hi;
   assign bus.Zero      = zero_r;
   assign bus.Overflow  = ovf_r;
   assign bus.Illegal   = ill_r;
   assign bus.Busy      = busy_r;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: 32-bit, 8-bit and multiplier-less instances against an arithmetic model.
module tb_alu_multicycle;
   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   alu_multicycle_if #(.WIDTH(32)) b32 ();
   alu_multicycle_if #(.WIDTH(8))  b8 ();
   alu_multicycle_if #(.WIDTH(32)) bn ();

   alu_multicycle #(.WIDTH(32), .MUL_ENABLE(1'b1)) dut32 (.Clk(clk), .Rst_n(rst_n), .bus(b32));
   alu_multicycle #(.WIDTH(8),  .MUL_ENABLE(1'b1)) dut8  (.Clk(clk), .Rst_n(rst_n), .bus(b8));
   alu_multicycle #(.WIDTH(32), .MUL_ENABLE(1'b0)) dutn  (.Clk(clk), .Rst_n(rst_n), .bus(bn));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: values treated as w-bit integers, results computed with 64-bit arithmetic.
   function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a, b,
                                 input bit mul_en, output logic [31:0] lo, hi,
                                 output logic z, ov, il);
      longint      sa, sb, r, maxv, minv;
      logic [63:0] mask, p, rv;
      int          sh;
      mask = (64'd1 << w) - 64'd1;
      sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      maxv = (longint'(1) << (w - 1)) - 1;
      minv = -(longint'(1) << (w - 1));
      sh   = int'(b % 32'(w));
      r = 0; hi = '0; ov = 1'b0; il = 1'b0;
      case (op)
         4'd0:  r = longint'(a & b);
         4'd1:  r = longint'(a | b);
         4'd12: r = longint'(~(a | b));
         4'd2:  begin r = sa + sb; ov = (r > maxv) || (r < minv); end
         4'd6:  begin r = sa - sb; ov = (r > maxv) || (r < minv); end
         4'd7:  r = (sa < sb) ? 1 : 0;
         4'd3:  r = longint'(a) << sh;
         4'd4:  r = longint'(a) >> sh;
         4'd5:  r = sa >>> sh;
         4'd8:  begin
            if (mul_en) begin
               p  = {32'd0, a} * {32'd0, b};
               r  = longint'(p);
               hi = 32'((p >> w) & mask);
            end else il = 1'b1;
         end
         default: il = 1'b1;
      endcase
      rv = r;
      lo = 32'(rv & mask);
      z  = (lo == 32'd0);
   endfunction

   task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a, b);
      logic [31:0] elo, ehi;
      logic        ez, eov, eil;
      int          lat;
      bit          hold_ok;
      model(32, op, a, b, 1'b1, elo, ehi, ez, eov, eil);
      @(negedge clk);
      b32.InValid = 1'b1; b32.ALUControl = op; b32.A = a; b32.B = b; b32.OutReady = 1'b1;
      @(posedge clk);
      #1 b32.InValid = 1'b0;
      lat = 1; hold_ok = 1'b1;
      @(negedge clk);
      while (b32.OutValid !== 1'b1 && lat < 40) begin
         if (b32.Busy !== 1'b1 || b32.InReady !== 1'b0) hold_ok = 1'b0;
         lat++;
         @(negedge clk);
      end
      chk({tag, ".latency"}, 64'(lat), (op == 4'b1000) ? 64'd33 : 64'd1);
      if (op == 4'b1000) chk({tag, ".busy_stall"}, 64'(hold_ok), 64'd1);
      chk({tag, ".lo"},   b32.ALUResult, elo);
      chk({tag, ".hi"},   b32.ResultHi, ehi);
      chk({tag, ".flags"}, {b32.Zero, b32.Overflow, b32.Illegal}, {ez, eov, eil});
   endtask

   task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a, b);
      logic [31:0] elo, ehi;
      logic        ez, eov, eil;
      int          lat;
      model(8, op, {24'd0, a}, {24'd0, b}, 1'b1, elo, ehi, ez, eov, eil);
      @(negedge clk);
      b8.InValid = 1'b1; b8.ALUControl = op; b8.A = a; b8.B = b; b8.OutReady = 1'b1;
      @(posedge clk);
      #1 b8.InValid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (b8.OutValid !== 1'b1 && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      chk({tag, ".latency"}, 64'(lat), (op == 4'b1000) ? 64'd9 : 64'd1);
      chk({tag, ".result"}, {b8.ResultHi, b8.ALUResult}, {elo[7:0] == 8'h00 ? 8'h00 : 8'h00, 8'h00} | {ehi[7:0], elo[7:0]});
      chk({tag, ".flags"}, {b8.Zero, b8.Overflow, b8.Illegal}, {ez, eov, eil});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int          lat;
      bit          seen;
      logic [3:0]  op;
      logic [31:0] ra, rb;

      rst_n = 1'b0;
      b32.InValid = 1'b0; b32.ALUControl = '0; b32.A = '0; b32.B = '0; b32.OutReady = 1'b1;
      b8.InValid  = 1'b0; b8.ALUControl  = '0; b8.A  = '0; b8.B  = '0; b8.OutReady  = 1'b1;
      bn.InValid  = 1'b0; bn.ALUControl  = '0; bn.A  = '0; bn.B  = '0; bn.OutReady  = 1'b1;
      #12;
      chk("reset.ctl", {b32.OutValid, b32.Busy, b32.Zero, b32.Overflow, b32.Illegal}, 64'd0);
      chk("reset.data", {b32.ALUResult, b32.ResultHi}, 64'd0);
      chk("reset.inready", b32.InReady, 64'd1);
      @(negedge clk) rst_n = 1'b1;

      run32("add", 4'b0010, 32'd15, 32'd10);
      chk("add.val", {b32.Zero, b32.ALUResult}, {1'b0, 32'd25});
      run32("sub_neg", 4'b0110, 32'd5, 32'd15);
      chk("sub_neg.val", b32.ALUResult, 32'hFFFF_FFF6);
      run32("sub_zero", 4'b0110, 32'd2, 32'd2);
      chk("sub_zero.val", {b32.Zero, b32.ALUResult}, {1'b1, 32'd0});
      run32("and", 4'b0000, 32'd15, 32'd0);
      run32("or", 4'b0001, 32'd15, 32'd0);
      chk("or.val", b32.ALUResult, 32'd15);
      run32("slt_lt", 4'b0111, 32'd0, 32'd15);
      chk("slt_lt.val", b32.ALUResult, 32'd1);
      run32("slt_gt", 4'b0111, 32'd15, 32'd0);
      chk("slt_gt.val", b32.ALUResult, 32'd0);
      run32("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd0);
      chk("slt_neg.val", b32.ALUResult, 32'd1);
      run32("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1);
      chk("add_ovf.val", {b32.Overflow, b32.ALUResult}, {1'b1, 32'h8000_0000});
      run32("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1);
      chk("sub_ovf.val", {b32.Overflow, b32.ALUResult}, {1'b1, 32'h7FFF_FFFF});
      run32("sra", 4'b0101, 32'h8000_0000, 32'd4);
      chk("sra.val", b32.ALUResult, 32'hF800_0000);
      run32("srl", 4'b0100, 32'h8000_0000, 32'd4);
      chk("srl.val", b32.ALUResult, 32'h0800_0000);
      run32("sll", 4'b0011, 32'd1, 32'h21);
      chk("sll.val", b32.ALUResult, 32'd2);
      run32("nor", 4'b1100, 32'h0F0F_0000, 32'h0000_00F0);
      run32("mult_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mult_max.val", {b32.ResultHi, b32.ALUResult}, 64'hFFFF_FFFE_0000_0001);
      run32("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
      chk("illegal.val", {b32.Illegal, b32.Zero, b32.ALUResult}, {1'b1, 1'b1, 32'd0});

      // Backpressure, then release together with a new accept.
      @(negedge clk);
      b32.OutReady = 1'b0; b32.InValid = 1'b1; b32.ALUControl = 4'b0010; b32.A = 32'd2; b32.B = 32'd2;
      @(posedge clk);
      #1 b32.InValid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.hold", {b32.OutValid, b32.InReady, b32.ALUResult}, {1'b1, 1'b0, 32'd4});
      end
      b32.OutReady = 1'b1; b32.InValid = 1'b1; b32.ALUControl = 4'b0001; b32.A = 32'd1; b32.B = 32'd2;
      #1 chk("bp.inready", b32.InReady, 64'd1);
      @(posedge clk);
      #1 b32.InValid = 1'b0;
      @(negedge clk);
      chk("bp.no_bubble", {b32.OutValid, b32.ALUResult}, {1'b1, 32'd3});

      for (int i = 0; i < 4; i++) begin
         b32.InValid = 1'b1; b32.ALUControl = 4'b0010; b32.A = 32'(i * 3); b32.B = 32'd7;
         @(posedge clk);
         @(negedge clk);
         chk("throughput", {b32.OutValid, b32.ALUResult}, {1'b1, 32'(i * 3 + 7)});
      end
      b32.InValid = 1'b0;

      for (int n = 0; n < 120; n++) begin
         op = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run32($sformatf("rnd%0d_op%0h", n, op), op, ra, rb);
      end

      // Asynchronous reset during iteration 10 of a multiply.
      @(negedge clk);
      b32.InValid = 1'b1; b32.ALUControl = 4'b1000; b32.A = $urandom | 32'h1; b32.B = $urandom | 32'h1;
      @(posedge clk);
      #1 b32.InValid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid.outs", {b32.OutValid, b32.Busy, b32.Zero, b32.Overflow, b32.Illegal}, 64'd0);
      chk("rst_mid.data", {b32.ALUResult, b32.ResultHi}, 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid.inready", b32.InReady, 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (b32.OutValid !== 1'b0 || b32.Busy !== 1'b0) seen = 1'b1;
      end
      chk("rst_mid.no_result", 64'(seen), 64'd0);

      run8("w8_mult", 4'b1000, 8'hFF, 8'h02);
      chk("w8_mult.val", {b8.ResultHi, b8.ALUResult}, 16'h01FE);
      run8("w8_sra", 4'b0101, 8'h80, 8'h0C);
      chk("w8_sra.val", b8.ALUResult, 8'hF8);
      run8("w8_add_ovf", 4'b0010, 8'h7F, 8'h01);
      run8("w8_mult_rnd", 4'b1000, 8'($urandom), 8'($urandom));

      @(negedge clk);
      bn.InValid = 1'b1; bn.ALUControl = 4'b1000; bn.A = $urandom | 32'h1; bn.B = $urandom | 32'h1;
      @(posedge clk);
      #1 bn.InValid = 1'b0;
      @(negedge clk);
      chk("nomul.illegal", {bn.OutValid, bn.Illegal, bn.Zero, bn.Busy, bn.ALUResult, bn.ResultHi},
          {1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
